// File: rtl/dense_accum_chunk.sv
// dense_accum_chunk: sums N_CHUNK consecutive partial sums from the 10-element
// inner-product pipeline into one dense-layer neuron output. The bias is folded
// in on the first beat, and an optional ReLU is applied to the final sum. The
// result sits in a one-entry output register with a valid/ready handshake.
module dense_accum_chunk #(
  parameter int DATA_WIDTH = 16,
  parameter int N_CHUNK    = 4,
  parameter bit RELU_EN    = 1'b1,
  localparam int IDX_W     = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] d,
  input  logic [DATA_WIDTH-1:0] bias,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] q,
  output logic [IDX_W-1:0]      chunk_idx,
  output logic                  drop_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHUNK - 1);

  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  out_valid_q, out_valid_d;
  logic                  drop_err_q, drop_err_d;

  logic                  is_first;
  logic                  is_last;
  logic                  accept;
  logic [DATA_WIDTH-1:0] sum;

  // Handshake and arithmetic; the inner pipeline cannot stall, so only the
  // last beat is ever held off, and only while an undrained result is held.
  always_comb begin
    is_first = (idx_q == '0);
    is_last  = (idx_q == LAST_IDX);
    in_ready = ~is_last | ~out_valid_q | out_ready;
    accept   = in_valid & in_ready & ~clear;
    sum      = (is_first ? bias : acc_q) + d;
  end

  // Next-state: clear overrides everything, then drops, accepts and drains.
  always_comb begin
    acc_d       = acc_q;
    res_d       = res_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    drop_err_d  = drop_err_q;

    if (clear) begin
      acc_d       = '0;
      idx_d       = '0;
      out_valid_d = 1'b0;
      drop_err_d  = 1'b0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
      if (in_valid && !in_ready) begin
        drop_err_d = 1'b1;
      end
      if (accept) begin
        if (is_last) begin
          // ReLU looks at the MSB of the wrapped sum, not a widened one.
          res_d       = (RELU_EN && sum[DATA_WIDTH-1]) ? '0 : sum;
          out_valid_d = 1'b1;
          idx_d       = '0;
          acc_d       = '0;
        end else begin
          acc_d = sum;
          idx_d = idx_q + 1'b1;
        end
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      res_q       <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      drop_err_q  <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      res_q       <= res_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      drop_err_q  <= drop_err_d;
    end
  end

  assign q         = res_q;
  assign out_valid = out_valid_q;
  assign chunk_idx = idx_q;
  assign drop_err  = drop_err_q;

endmodule

// File: tb/tb_dense_accum_chunk.sv
// Scoreboarded bench for dense_accum_chunk: one instance with ReLU, one without,
// fed identical directed beats; expected outputs are queued when stimulus is issued.
module tb_dense_accum_chunk;

  logic        clk = 1'b0;
  logic        rst_n, clear, in_valid, out_ready;
  logic [15:0] d, bias;

  logic        in_ready_r, out_valid_r, drop_err_r;
  logic [15:0] q_r;
  logic [1:0]  idx_r;
  logic        in_ready_l, out_valid_l, drop_err_l;
  logic [15:0] q_l;
  logic [1:0]  idx_l;

  int n_total = 0;
  int n_pass  = 0;

  logic [15:0] exp_r[$];
  logic [15:0] exp_l[$];

  always #5 clk = ~clk;

  dense_accum_chunk #(.DATA_WIDTH(16), .N_CHUNK(4), .RELU_EN(1'b1)) u_relu (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_r),
    .d(d), .bias(bias), .out_valid(out_valid_r), .out_ready(out_ready), .q(q_r),
    .chunk_idx(idx_r), .drop_err(drop_err_r));

  dense_accum_chunk #(.DATA_WIDTH(16), .N_CHUNK(4), .RELU_EN(1'b0)) u_lin (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_l),
    .d(d), .bias(bias), .out_valid(out_valid_l), .out_ready(out_ready), .q(q_l),
    .chunk_idx(idx_l), .drop_err(drop_err_l));

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%04h, expected 0x%04h at %0t", name, act, exp, $time);
  endtask

  task automatic expect_out(input logic [15:0] er, input logic [15:0] el);
    exp_r.push_back(er);
    exp_l.push_back(el);
  endtask

  // Present one beat that must be accepted; check the index it arrives at.
  task automatic send(input logic [15:0] dv, input logic [1:0] ei);
    in_valid = 1'b1;
    d        = dv;
    @(negedge clk);
    check("chunk_idx_before_beat", {14'd0, idx_r}, {14'd0, ei});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  // Monitors: pop and compare on every completed output transfer.
  always @(negedge clk) begin
    if (rst_n && out_valid_r && out_ready) begin
      if (exp_r.size() == 0) check("relu_unexpected_out", q_r, 16'hxxxx);
      else check("q_relu", q_r, exp_r.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid_l && out_ready) begin
      if (exp_l.size() == 0) check("lin_unexpected_out", q_l, 16'hxxxx);
      else check("q_lin", q_l, exp_l.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1; d = '0; bias = '0;
    #12;
    check("rst_q", q_r, 16'd0);
    check("rst_out_valid", {15'd0, out_valid_r}, 16'd0);
    check("rst_chunk_idx", {14'd0, idx_r}, 16'd0);
    check("rst_drop_err", {15'd0, drop_err_r}, 16'd0);
    #4 rst_n = 1'b1;
    step();

    // Basic accumulation: 10 + 100 + 200 + 300 + 400
    expect_out(16'd1010, 16'd1010);
    bias = 16'd10;
    send(16'd100, 2'd0);
    bias = 16'd7777;
    send(16'd200, 2'd1);
    send(16'd300, 2'd2);
    send(16'd400, 2'd3);
    @(negedge clk);
    check("basic_out_valid_rise", {15'd0, out_valid_r}, 16'd1);
    check("basic_idx_wrap", {14'd0, idx_r}, 16'd0);
    @(negedge clk);
    check("basic_out_valid_one_cycle", {15'd0, out_valid_r}, 16'd0);
    step();

    // ReLU and wrap: -500+300 = -200; 0x7FFF+1 wraps to 0x8000
    expect_out(16'h0000, 16'hFF38);
    bias = 16'd0;
    send(16'hFE0C, 2'd0);
    send(16'd100, 2'd1);
    send(16'd100, 2'd2);
    send(16'd100, 2'd3);
    expect_out(16'h0000, 16'h8000);
    send(16'h7FFF, 2'd0);
    send(16'd1, 2'd1);
    send(16'd0, 2'd2);
    send(16'd0, 2'd3);
    repeat (2) step();

    // Backpressure: hold 15, accumulate 1000+10+20+30, stall the last beat
    out_ready = 1'b0;
    expect_out(16'd15, 16'd15);
    bias = 16'd5;
    send(16'd1, 2'd0);
    send(16'd2, 2'd1);
    send(16'd3, 2'd2);
    send(16'd4, 2'd3);
    expect_out(16'd1100, 16'd1100);
    bias = 16'd1000;
    send(16'd10, 2'd0);
    send(16'd20, 2'd1);
    send(16'd30, 2'd2);
    in_valid = 1'b1; d = 16'd40;
    @(negedge clk);
    check("bp_in_ready_low", {15'd0, in_ready_r}, 16'd0);
    step();
    @(negedge clk);
    check("bp_idx_held", {14'd0, idx_r}, 16'd3);
    check("bp_q_held", q_r, 16'd15);
    check("bp_out_valid_held", {15'd0, out_valid_r}, 16'd1);
    step();
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready_on_drain", {15'd0, in_ready_r}, 16'd1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_no_gap_out_valid", {15'd0, out_valid_r}, 16'd1);
    check("bp_drop_err_from_stall", {15'd0, drop_err_r}, 16'd1);
    step();

    clear = 1'b1;
    step();
    clear = 1'b0;
    @(negedge clk);
    check("clear_drop_err", {15'd0, drop_err_r}, 16'd0);
    step();

    // Dropped beat: d=99 offered at idx 3 while result 4 is held
    out_ready = 1'b0;
    expect_out(16'd4, 16'd4);
    bias = 16'd0;
    send(16'd1, 2'd0);
    send(16'd1, 2'd1);
    send(16'd1, 2'd2);
    send(16'd1, 2'd3);
    expect_out(16'd15, 16'd15);
    bias = 16'd7;
    send(16'd2, 2'd0);
    send(16'd2, 2'd1);
    send(16'd2, 2'd2);
    in_valid = 1'b1; d = 16'd99;
    @(negedge clk);
    check("drop_in_ready_low", {15'd0, in_ready_r}, 16'd0);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("drop_err_set", {15'd0, drop_err_r}, 16'd1);
    check("drop_idx_unchanged", {14'd0, idx_r}, 16'd3);
    step();
    out_ready = 1'b1;
    send(16'd2, 2'd3);
    expect_out(16'd11, 16'd11);
    bias = 16'd1;
    send(16'd1, 2'd0);
    send(16'd2, 2'd1);
    send(16'd3, 2'd2);
    send(16'd4, 2'd3);
    repeat (2) step();
    @(negedge clk);
    check("drop_err_sticky", {15'd0, drop_err_r}, 16'd1);
    step();

    // clear mid-vector: held 20 is discarded, partial 50+1+2 is discarded
    out_ready = 1'b0;
    bias = 16'd0;
    send(16'd5, 2'd0);
    send(16'd5, 2'd1);
    send(16'd5, 2'd2);
    send(16'd5, 2'd3);
    bias = 16'd50;
    send(16'd1, 2'd0);
    send(16'd2, 2'd1);
    clear = 1'b1; in_valid = 1'b1; d = 16'd777;
    step();
    clear = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("clear_idx", {14'd0, idx_r}, 16'd0);
    check("clear_out_valid", {15'd0, out_valid_r}, 16'd0);
    check("clear_drop_err_beat", {15'd0, drop_err_r}, 16'd0);
    check("clear_q_holds", q_r, 16'd20);
    step();
    out_ready = 1'b1;
    expect_out(16'd310, 16'd310);
    bias = 16'd300;
    send(16'd1, 2'd0);
    bias = 16'd9999;
    send(16'd2, 2'd1);
    send(16'd3, 2'd2);
    send(16'd4, 2'd3);
    repeat (2) step();

    // Async reset while a result (32) is held
    out_ready = 1'b0;
    bias = 16'd0;
    send(16'd8, 2'd0);
    send(16'd8, 2'd1);
    send(16'd8, 2'd2);
    send(16'd8, 2'd3);
    @(negedge clk);
    check("pre_reset_out_valid", {15'd0, out_valid_r}, 16'd1);
    check("pre_reset_q", q_r, 16'd32);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_q", q_r, 16'd0);
    check("async_rst_out_valid", {15'd0, out_valid_r}, 16'd0);
    check("async_rst_idx", {14'd0, idx_r}, 16'd0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();

    for (int i = 0; i < 20 && (exp_r.size() != 0 || exp_l.size() != 0); i++) step();
    check("relu_queue_drained", 16'(exp_r.size()), 16'd0);
    check("lin_queue_drained", 16'(exp_l.size()), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
